// File: rtl/peri_pkg.sv
// Shared constants for the peripheral timer block: word offsets, TCON bit
// positions and the default address window.
package peri_pkg;

   // Register word offsets (addr[4:2])
   localparam logic [2:0] OFF_TH      = 3'd0;
   localparam logic [2:0] OFF_TL      = 3'd1;
   localparam logic [2:0] OFF_TCON    = 3'd2;
   localparam logic [2:0] OFF_LEDS    = 3'd3;
   localparam logic [2:0] OFF_DIGITS  = 3'd4;
   localparam logic [2:0] OFF_SYSTICK = 3'd5;

   // TCON bit indices
   localparam int unsigned TCON_EN   = 0;
   localparam int unsigned TCON_IE   = 1;
   localparam int unsigned TCON_IRQF = 2;

   // Default base of the 32-byte register window
   localparam logic [31:0] PERI_BASE_ADDR = 32'h4000_0000;

endpackage

// File: rtl/peri_timer_if.sv
// CPU load/store bus as seen by the peripheral block.
interface peri_timer_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] rdata;
   logic        hit;

   // CPU side drives address, data and strobes
   modport master (
      output addr, wdata, MemRead, MemWrite,
      input  rdata, hit
   );

   // Peripheral side decodes and returns read data
   modport slave (
      input  addr, wdata, MemRead, MemWrite,
      output rdata, hit
   );

endinterface

// File: rtl/peri_timer_core.sv
// Reloadable 32-bit up-counter with interrupt flag. Owns TH, TL and TCON
// and resolves CPU writes against same-cycle counting/reload events.
module peri_timer_core
   import peri_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_th,
   input  logic        we_tl,
   input  logic        we_tcon,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irq
);

   logic       ovf;
   logic       set_irqf;
   logic [2:0] irqf_mask;

   assign ovf      = tcon[TCON_EN] && (tl == '1);
   assign set_irqf = ovf && tcon[TCON_IE];

   // IRQF contribution of an overflow, ORed into any same-cycle TCON store
   always_comb begin
      irqf_mask            = '0;
      irqf_mask[TCON_IRQF] = set_irqf;
   end

   // Reload value; the reload in this same cycle still sees the old TH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     th <= '0;
      else if (we_th) th <= wdata;
   end

   // Counter: CPU write beats increment and reload
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              tl <= '0;
      else if (we_tl)          tl <= wdata;
      else if (tcon[TCON_EN]) tl <= (tl == '1) ? th : tl + 32'd1;
   end

   // Control/status: an overflow is never lost to a concurrent software clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        tcon <= '0;
      else if (we_tcon)  tcon <= wdata[2:0] | irqf_mask;
      else if (set_irqf) tcon[TCON_IRQF] <= 1'b1;
   end

   assign irq = tcon[TCON_IE] & tcon[TCON_IRQF];

endmodule

// File: rtl/peri_timer.sv
// Memory-mapped peripheral window: address decode, combinational read mux,
// LED/7-segment registers, free-running cycle counter and the timer core.
module peri_timer
   import peri_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = PERI_BASE_ADDR
)(
   input  logic          clk,
   input  logic          reset,
   peri_timer_if.slave   bus,
   output logic          irq,
   output logic [7:0]    leds,
   output logic [11:0]   digits
);

   logic [2:0]  off;
   logic        wr;
   logic        we_th;
   logic        we_tl;
   logic        we_tcon;
   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [31:0] systick;
   logic        unused_addr_bits;

   assign bus.hit = (bus.addr[31:5] == BASE_ADDR[31:5]);
   assign off     = bus.addr[4:2];
   assign wr      = bus.hit && bus.MemWrite;
   assign we_th   = wr && (off == OFF_TH);
   assign we_tl   = wr && (off == OFF_TL);
   assign we_tcon = wr && (off == OFF_TCON);

   // Byte lane bits are not decoded
   assign unused_addr_bits = ^bus.addr[1:0];

   peri_timer_core u_core (
      .clk     (clk),
      .reset   (reset),
      .we_th   (we_th),
      .we_tl   (we_tl),
      .we_tcon (we_tcon),
      .wdata   (bus.wdata),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irq     (irq)
   );

   // LED register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      leds <= '0;
      else if (wr && off == OFF_LEDS) leds <= bus.wdata[7:0];
   end

   // 7-segment register {anode, seg}
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        digits <= '0;
      else if (wr && off == OFF_DIGITS) digits <= bus.wdata[11:0];
   end

   // Free-running cycle counter, read-only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) systick <= '0;
      else        systick <= systick + 32'd1;
   end

   // Zero-latency read mux; zero when not selected or unmapped
   always_comb begin
      bus.rdata = '0;
      if (bus.hit && bus.MemRead) begin
         case (off)
            OFF_TH:      bus.rdata = th;
            OFF_TL:      bus.rdata = tl;
            OFF_TCON:    bus.rdata = {29'd0, tcon};
            OFF_LEDS:    bus.rdata = {24'd0, leds};
            OFF_DIGITS:  bus.rdata = {20'd0, digits};
            OFF_SYSTICK: bus.rdata = systick;
            default:     bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_peri_timer.sv
// Directed bench for peri_timer with a scoreboard of expected values.
module tb_peri_timer;
   import peri_pkg::*;

   logic        clk;
   logic        reset;
   logic        irq;
   logic [7:0]  leds;
   logic [11:0] digits;

   peri_timer_if bus_if ();

   peri_timer #(.BASE_ADDR(32'h4000_0000)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if),
      .irq    (irq),
      .leds   (leds),
      .digits (digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] ra(input logic [2:0] o);
      return 32'h4000_0000 | {27'd0, o, 2'b00};
   endfunction

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      string       tag;
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         tag = "scoreboard_empty";
         e   = 'x;
      end else begin
         tag = tag_q.pop_front();
         e   = exp_q.pop_front();
      end
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus_if.addr    = a;
      bus_if.MemRead = 1'b1;
      #1;
      d = bus_if.rdata;
      bus_if.MemRead = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.addr     = a;
      bus_if.wdata    = d;
      bus_if.MemWrite = 1'b1;
      cycle();
      bus_if.MemWrite = 1'b0;
      bus_if.addr     = '0;
      bus_if.wdata    = '0;
   endtask

   // Read a register and compare it against the queued expectation
   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] v);
      logic [31:0] d;
      expect_val(tag, v);
      rd(a, d);
      check(d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] s1;
      logic [31:0] s2;

      reset           = 1'b0;
      bus_if.addr     = '0;
      bus_if.wdata    = '0;
      bus_if.MemRead  = 1'b0;
      bus_if.MemWrite = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      expect_val("rst_leds", 32'd0);   check({24'd0, leds});
      expect_val("rst_digits", 32'd0); check({20'd0, digits});
      expect_val("rst_irq", 32'd0);    check({31'd0, irq});
      rd_chk("rst_th", ra(OFF_TH), 32'd0);
      rd_chk("rst_tcon", ra(OFF_TCON), 32'd0);
      rd_chk("rst_systick", ra(OFF_SYSTICK), 32'd0);

      // First counting edge is the first with reset high
      reset = 1'b1;
      rd_chk("systick_at_release", ra(OFF_SYSTICK), 32'd0);
      cycle();
      rd_chk("systick_first_edge", ra(OFF_SYSTICK), 32'd1);
      rd(ra(OFF_SYSTICK), s1);
      repeat (7) cycle();
      expect_val("systick_delta7", s1 + 32'd7);
      rd(ra(OFF_SYSTICK), s2);
      check(s2);

      // Reload and interrupt
      wr(ra(OFF_TH), 32'hFFFF_FFFC);
      wr(ra(OFF_TL), 32'hFFFF_FFFC);
      wr(ra(OFF_TCON), 32'h3);
      rd_chk("tl_seq0", ra(OFF_TL), 32'hFFFF_FFFC); cycle();
      rd_chk("tl_seq1", ra(OFF_TL), 32'hFFFF_FFFD); cycle();
      rd_chk("tl_seq2", ra(OFF_TL), 32'hFFFF_FFFE); cycle();
      rd_chk("tl_seq3", ra(OFF_TL), 32'hFFFF_FFFF);
      expect_val("irq_before_wrap", 32'd0); check({31'd0, irq});
      cycle();
      rd_chk("tl_reload", ra(OFF_TL), 32'hFFFF_FFFC);
      expect_val("irq_after_wrap", 32'd1); check({31'd0, irq});
      rd_chk("tcon_irqf_set", ra(OFF_TCON), 32'h7);
      wr(ra(OFF_TCON), 32'h3);
      expect_val("irq_cleared", 32'd0); check({31'd0, irq});
      rd_chk("tcon_cleared", ra(OFF_TCON), 32'h3);

      // Overflow coinciding with a clear store: IRQF survives
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      wr(ra(OFF_TCON), 32'h1);
      rd_chk("tcon_collide_001", ra(OFF_TCON), 32'h5);
      rd_chk("tl_collide_reload", ra(OFF_TL), 32'hFFFF_FFFC);
      wr(ra(OFF_TCON), 32'h3);
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      wr(ra(OFF_TCON), 32'h3);
      rd_chk("tcon_collide_011", ra(OFF_TCON), 32'h7);
      expect_val("irq_collide_011", 32'd1); check({31'd0, irq});
      wr(ra(OFF_TCON), 32'h3);
      expect_val("irq_clear2", 32'd0); check({31'd0, irq});

      // IE=0 overflow reloads but does not set IRQF
      wr(ra(OFF_TCON), 32'h1);
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      cycle();
      rd_chk("tcon_ie0_ovf", ra(OFF_TCON), 32'h1);
      rd_chk("tl_ie0_reload", ra(OFF_TL), 32'hFFFF_FFFC);

      // TL write beats increment
      wr(ra(OFF_TL), 32'h10);
      rd_chk("tl_write_win", ra(OFF_TL), 32'h10);
      cycle();
      rd_chk("tl_write_next", ra(OFF_TL), 32'h11);

      // TH store in reload cycle: reload uses old TH
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      wr(ra(OFF_TH), 32'h100);
      rd_chk("tl_old_th", ra(OFF_TL), 32'hFFFF_FFFC);
      rd_chk("th_new", ra(OFF_TH), 32'h100);

      // Disabling in the overflow cycle still reloads, then holds
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      wr(ra(OFF_TCON), 32'h0);
      rd_chk("tl_en0_reload", ra(OFF_TL), 32'h100);
      cycle(); cycle();
      rd_chk("tl_hold", ra(OFF_TL), 32'h100);

      // Decode
      wr(ra(OFF_LEDS), 32'h0000_00A5);
      expect_val("leds_a5", 32'hA5); check({24'd0, leds});
      bus_if.addr = 32'h4000_000C; #1;
      expect_val("hit_leds", 32'd1); check({31'd0, bus_if.hit});
      rd_chk("leds_byte_lane", 32'h4000_000F, 32'hA5);
      wr(32'h1000_000C, 32'h0000_005A);
      expect_val("leds_miss_store", 32'hA5); check({24'd0, leds});
      wr(ra(OFF_DIGITS), 32'hFFFF_FABC);
      expect_val("digits_out", 32'hABC); check({20'd0, digits});
      rd_chk("digits_rd", ra(OFF_DIGITS), 32'hABC);
      rd(ra(OFF_SYSTICK), s1);
      wr(ra(OFF_SYSTICK), 32'h0);
      expect_val("systick_ro", s1 + 32'd1);
      rd(ra(OFF_SYSTICK), s2);
      check(s2);
      wr(32'h4000_001C, 32'hDEAD_BEEF);
      rd_chk("unmapped_1c", 32'h4000_001C, 32'd0);
      rd_chk("unmapped_18", 32'h4000_0018, 32'd0);
      bus_if.addr = 32'h1000_0000; #1;
      expect_val("hit_miss", 32'd0); check({31'd0, bus_if.hit});
      rd_chk("rdata_miss", 32'h1000_0000, 32'd0);
      bus_if.addr = ra(OFF_LEDS); bus_if.MemRead = 1'b0; #1;
      expect_val("rdata_no_read", 32'd0); check(bus_if.rdata);

      // SYSTICK wrap
      cycle();
      force dut.systick = 32'hFFFF_FFFE;
      #1;
      release dut.systick;
      cycle();
      rd_chk("systick_ffff", ra(OFF_SYSTICK), 32'hFFFF_FFFF);
      cycle();
      rd_chk("systick_wrap", ra(OFF_SYSTICK), 32'd0);

      // Asynchronous reset mid-count with irq pending
      wr(ra(OFF_TH), 32'h1234);
      wr(ra(OFF_TCON), 32'h3);
      wr(ra(OFF_TL), 32'hFFFF_FFFF);
      cycle();
      expect_val("irq_pre_reset", 32'd1); check({31'd0, irq});
      reset = 1'b0;
      #1;
      expect_val("irq_async_rst", 32'd0);    check({31'd0, irq});
      expect_val("leds_async_rst", 32'd0);   check({24'd0, leds});
      expect_val("digits_async_rst", 32'd0); check({20'd0, digits});
      rd_chk("th_async_rst", ra(OFF_TH), 32'd0);
      rd_chk("tl_async_rst", ra(OFF_TL), 32'd0);
      rd_chk("tcon_async_rst", ra(OFF_TCON), 32'd0);
      rd_chk("systick_async_rst", ra(OFF_SYSTICK), 32'd0);
      reset = 1'b1;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
